// File: rtl/div_share_arbiter.sv
// -----------------------------------------------------------------------------
// div_share_arbiter
//
// Shares a single pipelined 20/10-bit divider core among NREQ requesters.
// A round-robin arbiter picks at most one requester per clock and registers
// its operands toward the core. A tag pipeline of LATENCY stages follows each
// operation through the core, so the quotient can be returned to the
// requester that issued it. Divide-by-zero operations still go through the
// core; their result is forced to all ones and flagged.
//
// Optional build macro:
//   DIV_SHARE_ARBITER_PRIO0_EN - requester 0 gets strict priority over the
//                                others; the round-robin pointer is frozen
//                                while requester 0 is being served.
//
// Parameters:
//   NREQ    - number of requesters (2..8)
//   LATENCY - divider core latency in clocks (>= 2)
//   IDW     - tag id width, 2**IDW >= NREQ
//
// Ports:
//   clk           in   system clock
//   rst_n         in   asynchronous active-low reset
//   req           in   per-requester request level, held until granted
//   req_dividend  in   packed dividends, requester i at [20i+19:20i]
//   req_divisor   in   packed divisors,  requester i at [10i+9:10i]
//   grant         out  one-hot grant for the current cycle; operands are
//                      captured on the following clock edge
//   div_dividend  out  dividend toward the divider core
//   div_divisor   out  divisor toward the divider core
//   div_quotient  in   quotient from the divider core
//   res_valid     out  one-hot, one-cycle result strobe
//   res_quotient  out  shared result bus, valid while any res_valid is high
//   res_dbz       out  divide-by-zero flag of the current result
//   outstanding   out  number of operations in flight (0..LATENCY+1)
// -----------------------------------------------------------------------------
module div_share_arbiter #(
  parameter int NREQ    = 4,
  parameter int LATENCY = 24,
  parameter int IDW     = 3
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [20*NREQ-1:0]   req_dividend,
  input  logic [10*NREQ-1:0]   req_divisor,
  output logic [NREQ-1:0]      grant,
  output logic [19:0]          div_dividend,
  output logic [9:0]           div_divisor,
  input  logic [19:0]          div_quotient,
  output logic [NREQ-1:0]      res_valid,
  output logic [19:0]          res_quotient,
  output logic                 res_dbz,
  output logic [4:0]           outstanding
);

  // ---------------------------------------------------------------------------
  // Arbitration
  // ---------------------------------------------------------------------------
  logic [IDW-1:0] rr_ptr;
  logic [IDW-1:0] ptr_next;

  logic           hi_found;
  logic [IDW-1:0] hi_id;
  logic           lo_found;
  logic [IDW-1:0] lo_id;

  logic           win_found;
  logic [IDW-1:0] win_id;
  logic [19:0]    win_dividend;
  logic [9:0]     win_divisor;

  // Two lowest-index searches: one restricted to indices at or above the
  // pointer, one over all requesters. If nothing sits at or above the pointer
  // the search wraps, and the lowest requesting index overall is the winner.
  always_comb begin
    hi_found = 1'b0;
    hi_id    = '0;
    lo_found = 1'b0;
    lo_id    = '0;
    for (int i = NREQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_found = 1'b1;
        lo_id    = IDW'(i);
        if (i >= int'(rr_ptr)) begin
          hi_found = 1'b1;
          hi_id    = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    win_found = hi_found | lo_found;
    win_id    = hi_found ? hi_id : lo_id;
`ifdef DIV_SHARE_ARBITER_PRIO0_EN
    if (req[0]) begin
      win_found = 1'b1;
      win_id    = '0;
    end
`endif
  end

  // Pointer advances past the winner with wrap; it holds when idle. In the
  // priority build it also holds while requester 0 is taking the slot, so the
  // others resume their rotation where they left off.
  always_comb begin
    ptr_next = rr_ptr;
    if (win_found) begin
      if (win_id == IDW'(NREQ - 1)) begin
        ptr_next = '0;
      end else begin
        ptr_next = win_id + IDW'(1);
      end
    end
`ifdef DIV_SHARE_ARBITER_PRIO0_EN
    if (req[0]) begin
      ptr_next = rr_ptr;
    end
`endif
  end

  always_comb begin
    win_dividend = '0;
    win_divisor  = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (win_id == IDW'(i)) begin
        win_dividend = req_dividend[20*i +: 20];
        win_divisor  = req_divisor[10*i +: 10];
      end
    end
  end

  // Grant is a decode of the winner so the requester sees it in the same
  // cycle its operands are captured; it is forced low during reset.
  always_comb begin
    grant = '0;
    for (int i = 0; i < NREQ; i++) begin
      grant[i] = rst_n & win_found & (win_id == IDW'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Issue: capture the winner's operands toward the core
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr       <= '0;
      div_dividend <= '0;
      div_divisor  <= '0;
    end else begin
      rr_ptr <= ptr_next;
      if (win_found) begin
        div_dividend <= win_dividend;
        div_divisor  <= win_divisor;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Tag pipeline: stage k holds the operation issued k+1 edges ago, so the
  // last stage lines up with the quotient coming out of the core.
  // ---------------------------------------------------------------------------
  logic [LATENCY-1:0] tag_valid;
  logic [LATENCY-1:0] tag_dbz;
  logic [IDW-1:0]     tag_id [LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tag_valid <= '0;
      tag_dbz   <= '0;
      for (int i = 0; i < LATENCY; i++) begin
        tag_id[i] <= '0;
      end
    end else begin
      tag_valid <= {tag_valid[LATENCY-2:0], win_found};
      tag_dbz   <= {tag_dbz[LATENCY-2:0], win_found && (win_divisor == 10'd0)};
      tag_id[0] <= win_id;
      for (int i = 1; i < LATENCY; i++) begin
        tag_id[i] <= tag_id[i-1];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Result return
  // ---------------------------------------------------------------------------
  logic           head_valid;
  logic           head_dbz;
  logic [IDW-1:0] head_id;

  assign head_valid = tag_valid[LATENCY-1];
  assign head_dbz   = tag_dbz[LATENCY-1];
  assign head_id    = tag_id[LATENCY-1];

  // The core's output is meaningless for a zero divisor, so it is replaced by
  // all ones. With no valid head the result bus keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      res_valid    <= '0;
      res_quotient <= '0;
      res_dbz      <= 1'b0;
    end else begin
      for (int i = 0; i < NREQ; i++) begin
        res_valid[i] <= head_valid && (head_id == IDW'(i));
      end
      res_dbz <= head_valid & head_dbz;
      if (head_valid) begin
        res_quotient <= head_dbz ? 20'hFFFFF : div_quotient;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // In-flight counter: an operation counts from its grant edge until the edge
  // that ends its result strobe, hence the LATENCY+1 maximum.
  // ---------------------------------------------------------------------------
  logic done_any;

  assign done_any = |res_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outstanding <= '0;
    end else begin
      case ({win_found, done_any})
        2'b10:   outstanding <= outstanding + 5'd1;
        2'b01:   outstanding <= outstanding - 5'd1;
        default: outstanding <= outstanding;
      endcase
    end
  end

endmodule
